branch_seq_ctrl: RTL and testbench
==================================

Name: branch_seq_ctrl

Overview:
Multi-cycle controller that sequences the branch datapath (RegFile read ports, ALU compare, branch-target adder) and owns the program counter. It accepts one instruction at a time over a valid/ready handshake. It drives the register read addresses and ALU operation, samples the ALU zero flag, resolves beq/bne, and commits the next PC. It sits between instruction fetch and the shared RegFile_32_32/ALU_32 pair.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
SUB_OP, 4'b0110, ALU_OP code driven during compare (subtract)
IDLE_OP, 4'b0000, ALU_OP code driven in all other states
CNT_W, 8, width of taken-branch counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
instr_valid  in  1  instruction present on instruction
instr_ready  out  1  controller can accept an instruction
instruction  in  32  MIPS instruction word
rs_addr  out  5  RegFile read port 1 address
rt_addr  out  5  RegFile read port 2 address
alu_op  out  4  ALU_OP to ALU_32
alu_zero  in  1  ALU zero flag (combinational from RegFile outputs)
pc  out  32  committed program counter
done  out  1  one-cycle pulse: pc updated for accepted instruction
branch_taken  out  1  result of last resolved instruction, valid with done
taken_count  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (rst==0 at rising edge): state=IDLE, pc=PC_RESET, done=0, branch_taken=0, taken_count=0, latched instruction=0. Reset mid-operation discards the in-flight instruction; no pc commit occurs.
- States: IDLE, READ, CMP, UPD.
- IDLE: instr_ready=1. On instr_valid&&instr_ready at an edge, latch instruction and go to READ. Otherwise stay in IDLE.
- READ: rs_addr=instr[25:21], rt_addr=instr[20:16] from the latched word. These are held through CMP. alu_op=IDLE_OP. Next state is CMP.
- CMP: alu_op=SUB_OP. At the edge, sample alu_zero and compute taken:
  - opcode 6'b000100 (beq): taken = alu_zero
  - opcode 6'b000101 (bne): taken = !alu_zero
  - any other opcode: taken = 0, alu_zero ignored
  - Register taken and target. Next state is UPD.
- Target arithmetic: target = pc + 4 + ({{14{imm[15]}}, imm[15:0], 2'b00}). Computed in 32 bits, modulo 2^32, so wrap-around is silent. Fall-through = pc + 4, also modulo 2^32.
- UPD: at the edge, pc <= taken ? target : fall-through. done <= 1 and branch_taken <= taken for exactly one cycle. If taken and taken_count != all-ones, taken_count increments; at all-ones it saturates and holds. Next state is IDLE.
- Latency: handshake at edge E0. pc, done and branch_taken become visible in the cycle after edge E3. instr_ready is high in that same cycle, so back-to-back instructions are accepted at one per 4 cycles.
- instr_ready is 0 in READ/CMP/UPD. instr_valid and instruction are ignored outside IDLE. The latched copy is used, so source changes after the handshake have no effect.
- rs_addr/rt_addr in IDLE are 0. alu_op is IDLE_OP in every state except CMP.
- done is registered and never high for two consecutive cycles.

Test Plan:
1. pc=0x100, beq r1,r2 imm=1, bench drives alu_zero=1 in CMP -> done after 4 cycles, branch_taken=1, pc=0x108, taken_count=1, alu_op=0110 only in CMP, rs_addr=1, rt_addr=2 in READ/CMP.
2. pc=0x100, bne imm=1, alu_zero=1 -> branch_taken=0, pc=0x104, taken_count unchanged. Repeat with alu_zero=0 -> taken, pc=0x10C.
3. pc=0x100, beq imm=16'hFFFF, taken -> pc=0x100 (self-loop). With PC_RESET=0xFFFFFFF8 and non-branch opcode (0x20220001) -> pc=0xFFFFFFFC, then next -> 0x00000000 (wrap).
4. Hold instr_valid=1 continuously with changing instruction -> accepted only in IDLE, one per 4 cycles. Changes during READ/CMP do not alter result. done is a single-cycle pulse.
5. Drive rst=0 during CMP of a taken beq -> next cycle pc=PC_RESET, done=0, taken_count=0, state IDLE (instr_ready=1). No later commit occurs.
6. Run 260 taken beq instructions with CNT_W=8 -> taken_count saturates at 255 and stays at 255.

Source files
------------

// File: rtl/branch_seq_ctrl_if.sv
// Branch controller bus: fetch handshake,
// RegFile/ALU control and commit outputs.
interface branch_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instruction;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [3:0]       alu_op;
  logic             alu_zero;
  logic [31:0]      pc;
  logic             done;
  logic             branch_taken;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output instr_valid,
    output instruction,
    output alu_zero,
    input  instr_ready,
    input  rs_addr,
    input  rt_addr,
    input  alu_op,
    input  pc,
    input  done,
    input  branch_taken,
    input  taken_count
  );

  modport slave (
    input  instr_valid,
    input  instruction,
    input  alu_zero,
    output instr_ready,
    output rs_addr,
    output rt_addr,
    output alu_op,
    output pc,
    output done,
    output branch_taken,
    output taken_count
  );
endinterface

// File: rtl/branch_seq_ctrl.sv
// Multi-cycle beq/bne sequencer that drives the
// RegFile/ALU compare and owns the program counter.
module branch_seq_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [3:0]  SUB_OP   = 4'b0110,
  parameter logic [3:0]  IDLE_OP  = 4'b0000,
  parameter int          CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  branch_seq_ctrl_if.slave  bus
);

  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_BNE = 6'b000101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_UPD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_instr;
  logic [31:0]      r_pc;
  logic [31:0]      r_target;
  logic             r_res_tk;
  logic             r_done;
  logic             r_taken;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_tk;
  logic [5:0]       w_opc;
  logic [31:0]      w_seq;
  logic [31:0]      w_imm;
  logic [31:0]      w_target;

  assign w_opc    = r_instr[31:26];
  assign w_seq    = r_pc + 32'd4;
  assign w_imm    = {{14{r_instr[15]}},
                     r_instr[15:0], 2'b00};
  assign w_target = w_seq + w_imm;
  assign w_accept = (r_state == S_IDLE)
                  && bus.instr_valid;

  assign bus.pc           = r_pc;
  assign bus.done         = r_done;
  assign bus.branch_taken = r_taken;
  assign bus.taken_count  = r_cnt;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // next state and per-state control outputs
  always_comb begin
    w_next          = r_state;
    bus.instr_ready = 1'b0;
    bus.rs_addr     = 5'd0;
    bus.rt_addr     = 5'd0;
    bus.alu_op      = IDLE_OP;
    unique case (r_state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) w_next = S_READ;
      end
      S_READ: begin
        bus.rs_addr = r_instr[25:21];
        bus.rt_addr = r_instr[20:16];
        w_next      = S_CMP;
      end
      S_CMP: begin
        bus.rs_addr = r_instr[25:21];
        bus.rt_addr = r_instr[20:16];
        bus.alu_op  = SUB_OP;
        w_next      = S_UPD;
      end
      S_UPD: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // branch resolution from opcode and zero flag
  always_comb begin
    w_tk = 1'b0;
    unique case (1'b1)
      (w_opc == OPC_BEQ): w_tk = bus.alu_zero;
      (w_opc == OPC_BNE): w_tk = !bus.alu_zero;
      default:            w_tk = 1'b0;
    endcase
  end

  // latch, resolve and commit datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instr  <= 32'd0;
      r_pc     <= PC_RESET;
      r_target <= 32'd0;
      r_res_tk <= 1'b0;
      r_done   <= 1'b0;
      r_taken  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_taken <= 1'b0;
      if (w_accept) r_instr <= bus.instruction;
      if (r_state == S_CMP) begin
        r_res_tk <= w_tk;
        r_target <= w_target;
      end
      if (r_state == S_UPD) begin
        r_pc    <= r_res_tk ? r_target : w_seq;
        r_done  <= 1'b1;
        r_taken <= r_res_tk;
        if (r_res_tk && (r_cnt != '1))
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl: two
// instances with different reset PCs in lockstep.
module tb_branch_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        alu_zero;
  int          n_checks;
  int          n_err;

  branch_seq_ctrl_if #(.CNT_W(8)) ifa ();
  branch_seq_ctrl_if #(.CNT_W(8)) ifb ();

  assign ifa.instr_valid = instr_valid;
  assign ifa.instruction = instruction;
  assign ifa.alu_zero    = alu_zero;
  assign ifb.instr_valid = instr_valid;
  assign ifb.instruction = instruction;
  assign ifb.alu_zero    = alu_zero;

  branch_seq_ctrl #(
    .PC_RESET(32'h0000_0100),
    .CNT_W(8)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .bus(ifa)
  );

  branch_seq_ctrl #(
    .PC_RESET(32'hFFFF_FFF8),
    .CNT_W(8)
  ) u_b (
    .clk(clk),
    .rst(rst),
    .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h, expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One instruction through IDLE/READ/CMP/UPD.
  // hold keeps valid high and scrambles the
  // source word after the handshake.
  task automatic issue(
    input logic [31:0] ins,
    input logic        z,
    input logic        hold,
    input logic        etk,
    input logic [31:0] epc,
    input logic [7:0]  ecnt
  );
    logic [4:0] ers;
    logic [4:0] ert;
    ers = ins[25:21];
    ert = ins[20:16];
    chk("idle_ready", ifa.instr_ready, 1);
    instr_valid = 1'b1;
    instruction = ins;
    alu_zero    = ~z;
    @(negedge clk);
    chk("read_ready", ifa.instr_ready, 0);
    chk("read_done", ifa.done, 0);
    chk("read_rs", ifa.rs_addr, ers);
    chk("read_rt", ifa.rt_addr, ert);
    chk("read_op", ifa.alu_op, 4'b0000);
    instr_valid = hold;
    if (hold) instruction = $urandom;
    alu_zero = z;
    @(negedge clk);
    chk("cmp_ready", ifa.instr_ready, 0);
    chk("cmp_rs", ifa.rs_addr, ers);
    chk("cmp_rt", ifa.rt_addr, ert);
    chk("cmp_op", ifa.alu_op, 4'b0110);
    if (hold) instruction = $urandom;
    @(negedge clk);
    chk("upd_ready", ifa.instr_ready, 0);
    chk("upd_done", ifa.done, 0);
    chk("upd_op", ifa.alu_op, 4'b0000);
    alu_zero = ~z;
    if (hold) instruction = $urandom;
    @(negedge clk);
    chk("done", ifa.done, 1);
    chk("taken", ifa.branch_taken, etk);
    chk("pc", ifa.pc, epc);
    chk("count", ifa.taken_count, ecnt);
    chk("done_ready", ifa.instr_ready, 1);
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    instruction = 32'd0;
    alu_zero    = 1'b0;
    do_reset();

    chk("rst_pc", ifa.pc, 32'h100);
    chk("rst_done", ifa.done, 0);
    chk("rst_tk", ifa.branch_taken, 0);
    chk("rst_cnt", ifa.taken_count, 0);
    chk("rst_ready", ifa.instr_ready, 1);
    chk("rst_rs", ifa.rs_addr, 0);
    chk("rst_rt", ifa.rt_addr, 0);
    chk("rst_op", ifa.alu_op, 0);
    chk("rst_b_pc", ifb.pc, 32'hFFFF_FFF8);

    // beq r1,r2,+1 taken
    issue(32'h1022_0001, 1, 0, 1,
          32'h108, 8'd1);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pulse_end", ifa.done, 0);
    chk("idle_rs", ifa.rs_addr, 0);

    // bne not taken, then taken
    do_reset();
    issue(32'h1422_0001, 1, 0, 0,
          32'h104, 8'd0);
    issue(32'h1422_0001, 0, 0, 1,
          32'h10C, 8'd1);

    // beq -1 word: self-loop
    do_reset();
    issue(32'h1022_FFFF, 1, 0, 1,
          32'h100, 8'd1);

    // non-branch, alu_zero ignored; B wraps
    do_reset();
    chk("b_rst_pc", ifb.pc, 32'hFFFF_FFF8);
    issue(32'h2022_0001, 1, 0, 0,
          32'h104, 8'd0);
    chk("b_pc1", ifb.pc, 32'hFFFF_FFFC);
    chk("b_tk1", ifb.branch_taken, 0);
    issue(32'h2022_0001, 1, 0, 0,
          32'h108, 8'd0);
    chk("b_pc2", ifb.pc, 32'h0000_0000);

    // valid held high, source scrambled
    do_reset();
    issue(32'h1064_0002, 1, 1, 1,
          32'h10C, 8'd1);
    issue(32'h1464_0002, 1, 1, 0,
          32'h110, 8'd1);
    issue(32'h1064_FFFE, 0, 1, 0,
          32'h114, 8'd1);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("hold_pulse", ifa.done, 0);
    chk("hold_ready", ifa.instr_ready, 1);

    // reset during CMP of a taken beq
    instr_valid = 1'b1;
    instruction = 32'h1022_0001;
    alu_zero    = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("r5_cmp_op", ifa.alu_op, 4'b0110);
    rst = 1'b0;
    @(negedge clk);
    chk("r5_pc", ifa.pc, 32'h100);
    chk("r5_done", ifa.done, 0);
    chk("r5_cnt", ifa.taken_count, 0);
    chk("r5_ready", ifa.instr_ready, 1);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("r5_nodone", ifa.done, 0);
      chk("r5_pc_hold", ifa.pc, 32'h100);
    end

    // saturation of the taken counter
    do_reset();
    for (int i = 1; i <= 260; i++) begin
      issue(32'h1022_0001, 1, 0, 1,
            32'h100 + 32'(8 * i),
            (i > 255) ? 8'd255 : 8'(i));
    end
    instr_valid = 1'b0;
    @(negedge clk);
    chk("sat_final", ifa.taken_count, 255);
    chk("sat_pc", ifa.pc, 32'h920);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
